// File: rtl/multiplicador_uc_if.sv
// Control/handshake bundle between the multiplier control unit, its requester
// and the shift-add datapath it sequences.
interface multiplicador_uc_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    // Requester side
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             p_valid;
    logic [2:0]       state_dbg;

    // Datapath status
    logic             qlsb;
    logic             zero;

    // Datapath controls
    logic             a_rst;
    logic             a_en;
    logic             a_ld;
    logic             b_en;
    logic             b_ld;
    logic             q_en;
    logic             q_ld;
    logic             cnt_en;
    logic             cnt_ld;
    logic [CNT_W-1:0] cnt_init;

    // Control unit view: drives every control, reads request and status flags.
    modport master (
        input  start, abort, qlsb, zero,
        output a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld,
               cnt_en, cnt_ld, cnt_init,
               busy, done, p_valid, state_dbg
    );

    // Environment view: requester plus datapath.
    modport slave (
        output start, abort, qlsb, zero,
        input  a_rst, a_en, a_ld, b_en, b_ld, q_en, q_ld,
               cnt_en, cnt_ld, cnt_init,
               busy, done, p_valid, state_dbg
    );
endinterface

// File: rtl/multiplicador_uc.sv
// Moore control unit for a shift-add multiplier: INIT loads the datapath,
// then one TEST/(ADD)/SHIFT iteration runs per multiplier bit, then DONE.
module multiplicador_uc #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    multiplicador_uc_if.master  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic a_rst;
        logic a_en;
        logic a_ld;
        logic b_en;
        logic b_ld;
        logic q_en;
        logic q_ld;
        logic cnt_en;
        logic cnt_ld;
        logic busy;
        logic done;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   p_valid;

    // Moore decode of a state into its control word.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_INIT:  begin
                c.a_rst = 1'b1;  c.a_en = 1'b1;  c.a_ld = 1'b1;
                c.b_en  = 1'b1;  c.b_ld = 1'b1;
                c.q_en  = 1'b1;  c.q_ld = 1'b1;
                c.cnt_en = 1'b1; c.cnt_ld = 1'b1;
                c.busy  = 1'b1;
            end
            S_TEST:  c.busy = 1'b1;
            S_ADD:   begin c.a_en = 1'b1; c.a_ld = 1'b1; c.busy = 1'b1; end
            S_SHIFT: begin
                c.a_en = 1'b1; c.q_en = 1'b1; c.cnt_en = 1'b1; c.busy = 1'b1;
            end
            S_DONE:  begin c.busy = 1'b1; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; abort wins over everything except reset.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = (bus.start && !bus.abort) ? S_INIT : S_IDLE;
            S_INIT:  state_nxt = bus.abort ? S_IDLE : S_TEST;
            S_TEST:  state_nxt = bus.abort ? S_IDLE : (bus.qlsb ? S_ADD : S_SHIFT);
            S_ADD:   state_nxt = bus.abort ? S_IDLE : S_SHIFT;
            S_SHIFT: state_nxt = bus.abort ? S_IDLE : (bus.zero ? S_DONE : S_TEST);
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, registered control word (decoded from next state) and product flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state   <= S_IDLE;
            ctrl    <= '0;
            p_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ctrl  <= decode(state_nxt);
            if (bus.abort)
                p_valid <= 1'b0;
            else if (state == S_DONE)
                p_valid <= 1'b1;
            else if (state_nxt == S_INIT)
                p_valid <= 1'b0;
        end
    end

    assign bus.a_rst     = ctrl.a_rst;
    assign bus.a_en      = ctrl.a_en;
    assign bus.a_ld      = ctrl.a_ld;
    assign bus.b_en      = ctrl.b_en;
    assign bus.b_ld      = ctrl.b_ld;
    assign bus.q_en      = ctrl.q_en;
    assign bus.q_ld      = ctrl.q_ld;
    assign bus.cnt_en    = ctrl.cnt_en;
    assign bus.cnt_ld    = ctrl.cnt_ld;
    assign bus.busy      = ctrl.busy;
    assign bus.done      = ctrl.done;
    assign bus.p_valid   = p_valid;
    assign bus.state_dbg = state;
    assign bus.cnt_init  = CNT_W'(WIDTH - 1);
endmodule

// File: tb/tb_multiplicador_uc.sv
// Bench for multiplicador_uc: behavioural shift-add datapath plus directed
// multiplication vectors and hand-written abort / reset / start-corner sequences.
module tb_multiplicador_uc;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    multiplicador_uc_if #(.WIDTH(W)) bus ();

    multiplicador_uc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: carry:A:Q shift-right, B operand, down-counter.
    logic         c_r;
    logic [W-1:0] a_r, b_r, q_r;
    logic [2:0]   cnt_r;
    logic [W-1:0] b_in, q_in;

    always @(posedge clk) begin
        if (bus.a_en && bus.a_ld) begin
            if (bus.a_rst) {c_r, a_r} <= '0;
            else           {c_r, a_r} <= {1'b0, a_r} + {1'b0, b_r};
        end
        if (bus.b_en && bus.b_ld) b_r <= b_in;
        if (bus.q_en && bus.q_ld) q_r <= q_in;
        if (bus.a_en && !bus.a_ld && bus.q_en && !bus.q_ld)
            {c_r, a_r, q_r} <= {c_r, a_r, q_r} >> 1;
        if (bus.cnt_en && bus.cnt_ld)       cnt_r <= bus.cnt_init;
        else if (bus.cnt_en)                cnt_r <= cnt_r - 3'd1;
    end

    assign bus.qlsb = q_r[0];
    assign bus.zero = (cnt_r == 3'd0);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] ctrl_now();
        return {bus.a_rst, bus.a_en, bus.a_ld, bus.b_en, bus.b_ld, bus.q_en,
                bus.q_ld, bus.cnt_en, bus.cnt_ld, bus.busy, bus.done};
    endfunction

    // Expected control word per state, bit order as ctrl_now().
    function automatic logic [10:0] ctrl_exp(input logic [2:0] s);
        case (s)
            3'd1:    return 11'b111_1111_1110;
            3'd2:    return 11'b000_0000_0010;
            3'd3:    return 11'b011_0000_0010;
            3'd4:    return 11'b010_0010_1010;
            3'd5:    return 11'b000_0000_0011;
            default: return 11'b000_0000_0000;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
        int             lat;
        int             adds;
    } vec_t;

    // Runs one multiplication and checks latency, iteration counts and product.
    task automatic run_vec(input vec_t v, input bit mid_start);
        int lat, adds, shifts;
        adds = 0; shifts = 0;
        @(negedge clk);
        b_in = v.b; q_in = v.q; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        check("first_state_init", bus.state_dbg, 3'd1);
        check("p_valid_cleared_init", bus.p_valid, 1'b0);
        while (lat < 60) begin
            check($sformatf("decode_s%0d", bus.state_dbg), ctrl_now(), ctrl_exp(bus.state_dbg));
            if (bus.state_dbg == 3'd3) adds++;
            if (bus.state_dbg == 3'd4) shifts++;
            if (bus.done) break;
            if (mid_start) bus.start = (lat == 5);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("latency", lat, v.lat);
        check("add_cycles", adds, v.adds);
        check("shift_cycles", shifts, W);
        check("product", {a_r, q_r}, v.p);
        check("p_valid_in_done", bus.p_valid, 1'b0);
        @(negedge clk);
        check("p_valid_after_done", bus.p_valid, 1'b1);
        check("idle_after_done", {bus.state_dbg, bus.busy, bus.done}, 5'b000_0_0);
        repeat (3) @(negedge clk);
        check("p_valid_held", bus.p_valid, 1'b1);
    endtask

    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = '{8'h0D, 8'h00, 16'h0000, 18, 0};
        vecs[1] = '{8'h0D, 8'hA5, 16'h0861, 22, 4};
        vecs[2] = '{8'hFF, 8'hFF, 16'hFE01, 26, 8};
        vecs[3] = '{8'h01, 8'h80, 16'h0080, 19, 1};
        vecs[4] = '{8'h80, 8'h03, 16'h0180, 20, 2};
        vecs[5] = '{8'hFF, 8'h01, 16'h00FF, 19, 1};

        rst = 1'b0; bus.start = 1'b1; bus.abort = 1'b0;
        b_in = '0; q_in = '0;

        // Reset held with start high: everything stays idle and cleared.
        repeat (2) begin
            @(negedge clk);
            check("rst_state", bus.state_dbg, 3'd0);
            check("rst_ctrl", ctrl_now(), 11'd0);
            check("rst_p_valid", bus.p_valid, 1'b0);
        end
        check("cnt_init", bus.cnt_init, 3'd7);
        bus.start = 1'b0;
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // Start pulsed again while busy: same latency and result.
        run_vec(vecs[1], 1'b1);

        // Abort during the third SHIFT.
        @(negedge clk);
        b_in = 8'h0D; q_in = 8'hA5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            if (bus.state_dbg == 3'd4) n++;
            if (n < 3) @(negedge clk);
        end
        check("reached_third_shift", n, 3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_state", bus.state_dbg, 3'd0);
        check("abort_ctrl", ctrl_now(), 11'd0);
        check("abort_p_valid", bus.p_valid, 1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done || bus.state_dbg != 3'd0) n++;
        end
        check("abort_stays_idle", n, 0);
        run_vec(vecs[1], 1'b0);

        // start and abort together in IDLE: no operation begins.
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("start_abort_idle", {bus.state_dbg, bus.busy}, 4'b000_0);
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_p_valid", bus.p_valid, 1'b0);

        // Reset during an ADD cycle, then a full-scale multiplication.
        @(negedge clk);
        b_in = 8'h0D; q_in = 8'hA5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n == 0; i++) begin
            if (bus.state_dbg == 3'd3) n = 1;
            else @(negedge clk);
        end
        check("reached_add", n, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", bus.state_dbg, 3'd0);
        check("midrst_ctrl", ctrl_now(), 11'd0);
        check("midrst_p_valid", bus.p_valid, 1'b0);
        rst = 1'b1;
        run_vec(vecs[2], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
